// File: rtl/cir_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cir_reg_pkg
// Description : Shared defaults and encodings for the circular weight
//               register. Holds the default geometry, the rotation
//               direction codes and the weight element type.
// Revision    : 1.0 - initial release
// ============================================================================
package cir_reg_pkg;

  // Default geometry: element width, kernel height (rows), kernel width (ring length)
  localparam int DEF_DW  = 8;
  localparam int DEF_K_H = 3;
  localparam int DEF_K_W = 3;

  // shift_dir encoding
  localparam logic ROT_UP = 1'b0;  // toward higher column index
  localparam logic ROT_DN = 1'b1;  // toward lower column index

  // One weight element at the default width
  typedef logic [DEF_DW-1:0] weight_t;

endpackage : cir_reg_pkg
`default_nettype wire

// File: rtl/cir_bank.sv
`default_nettype none
// ============================================================================
// Module      : cir_bank
// Description : One K_H x K_W weight bank. A load shifts every row toward the
//               higher column index and inserts the new column at column 0.
//               Rotation moves the whole ring one position either way.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_clr             - synchronous clear of all storage
//               i_load            - insert i_load_data at column 0
//               i_load_data       - column to insert, element i -> row i
//               i_rotate_up       - ring shift toward higher column index
//               i_rotate_dn       - ring shift toward lower column index
//               o_head / o_tail   - column 0 / column K_W-1 taps
// Revision    : 1.0 - initial release
// ============================================================================
module cir_bank
  import cir_reg_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int K_H = DEF_K_H,
  parameter int K_W = DEF_K_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_load,
  input  logic [K_H-1:0][DW-1:0]  i_load_data,
  input  logic                    i_rotate_up,
  input  logic                    i_rotate_dn,
  output logic [K_H-1:0][DW-1:0]  o_head,
  output logic [K_H-1:0][DW-1:0]  o_tail
);

  logic [K_H-1:0][K_W-1:0][DW-1:0] r_mem;

  // Load and rotate are never requested together by the top; load wins
  // anyway so the bank stays well defined on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (i_clr) begin
      r_mem <= '0;
    end else if (i_load) begin
      for (int i = 0; i < K_H; i++) begin
        for (int j = 1; j < K_W; j++) r_mem[i][j] <= r_mem[i][j-1];
        r_mem[i][0] <= i_load_data[i];
      end
    end else if (i_rotate_up) begin
      for (int i = 0; i < K_H; i++) begin
        for (int j = 1; j < K_W; j++) r_mem[i][j] <= r_mem[i][j-1];
        r_mem[i][0] <= r_mem[i][K_W-1];
      end
    end else if (i_rotate_dn) begin
      for (int i = 0; i < K_H; i++) begin
        for (int j = 0; j < K_W-1; j++) r_mem[i][j] <= r_mem[i][j+1];
        r_mem[i][K_W-1] <= r_mem[i][0];
      end
    end
  end

  generate
    for (genvar i = 0; i < K_H; i++) begin : g_taps
      assign o_head[i] = r_mem[i][0];
      assign o_tail[i] = r_mem[i][K_W-1];
    end
  endgenerate

endmodule : cir_bank
`default_nettype wire

// File: rtl/cir_reg_w_pp.sv
`default_nettype none
// ============================================================================
// Module      : cir_reg_w_pp
// Description : Double-buffered circular weight register. The shadow bank is
//               filled column by column over a valid/ready handshake while
//               the active bank rotates to feed the PE row lanes. The banks
//               swap when the shadow is full and the active bank is free or
//               being released.
// Ports       : clk, rst_n            - clock, async active-low reset
//               clear                 - synchronous clear of all state
//               in_valid/in_ready     - load column handshake
//               in_data               - load column, element i -> row i
//               shift_en / shift_dir  - rotate active bank (0 up, 1 down)
//               bank_release          - consumer done with the active bank
//                                       ("release" is a reserved word)
//               act_valid             - active bank holds valid weights
//               out_head / out_tail   - active column 0 / column K_W-1
//               rot_cnt               - rotation position 0..K_W-1
//               rot_wrap              - pulse: rotation came back to 0
// Revision    : 1.0 - initial release
// ============================================================================
module cir_reg_w_pp
  import cir_reg_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int K_H = DEF_K_H,
  parameter int K_W = DEF_K_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [K_H-1:0][DW-1:0]   in_data,
  input  logic                     shift_en,
  input  logic                     shift_dir,
  input  logic                     bank_release,
  output logic                     act_valid,
  output logic [K_H-1:0][DW-1:0]   out_head,
  output logic [K_H-1:0][DW-1:0]   out_tail,
  output logic [$clog2(K_W)-1:0]   rot_cnt,
  output logic                     rot_wrap
);

  localparam int CW  = $clog2(K_W);
  localparam int CCW = $clog2(K_W + 1);

  localparam logic [CW-1:0]  C_ROT_LAST = CW'(K_W - 1);
  localparam logic [CCW-1:0] C_COL_FULL = CCW'(K_W);

  logic            r_act_sel;
  logic            r_act_valid;
  logic [CCW-1:0]  r_col_cnt;
  logic [CW-1:0]   r_rot_cnt;
  logic            r_rot_wrap;

  logic            w_full;
  logic            w_in_ready;
  logic            w_load;
  logic            w_swap;
  logic            w_rel_empty;
  logic            w_rotate;
  logic [CW-1:0]   w_rot_nxt;

  logic [1:0][K_H-1:0][DW-1:0] w_head;
  logic [1:0][K_H-1:0][DW-1:0] w_tail;

  assign w_full      = (r_col_cnt == C_COL_FULL);
  assign w_in_ready  = !w_full && !clear;
  assign w_load      = in_valid && w_in_ready;
  assign w_swap      = w_full && (!r_act_valid || bank_release);
  // A release with nothing waiting in the shadow just frees the active bank.
  assign w_rel_empty = bank_release && !w_full;
  assign w_rotate    = r_act_valid && shift_en && !w_swap && !w_rel_empty;

  always_comb begin
    w_rot_nxt = r_rot_cnt;
    if (shift_dir == ROT_UP) begin
      w_rot_nxt = (r_rot_cnt == C_ROT_LAST) ? '0 : r_rot_cnt + CW'(1);
    end else begin
      w_rot_nxt = (r_rot_cnt == '0) ? C_ROT_LAST : r_rot_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_sel   <= 1'b0;
      r_act_valid <= 1'b0;
      r_col_cnt   <= '0;
      r_rot_cnt   <= '0;
      r_rot_wrap  <= 1'b0;
    end else if (clear) begin
      r_act_sel   <= 1'b0;
      r_act_valid <= 1'b0;
      r_col_cnt   <= '0;
      r_rot_cnt   <= '0;
      r_rot_wrap  <= 1'b0;
    end else begin
      r_rot_wrap <= 1'b0;
      if (w_swap) begin
        r_act_sel   <= ~r_act_sel;
        r_act_valid <= 1'b1;
        r_rot_cnt   <= '0;
        r_col_cnt   <= '0;
      end else begin
        if (w_rel_empty) begin
          r_act_valid <= 1'b0;
        end else if (w_rotate) begin
          r_rot_cnt  <= w_rot_nxt;
          r_rot_wrap <= (w_rot_nxt == '0);
        end
        // in_ready is low whenever a swap is possible, so loads only land here
        if (w_load) r_col_cnt <= r_col_cnt + CCW'(1);
      end
    end
  end

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      localparam logic C_SEL = 1'(b);
      logic w_is_act;
      assign w_is_act = (r_act_sel == C_SEL);

      cir_bank #(
        .DW  (DW),
        .K_H (K_H),
        .K_W (K_W)
      ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (clear),
        .i_load      (w_load && !w_is_act),
        .i_load_data (in_data),
        .i_rotate_up (w_rotate && w_is_act && (shift_dir == ROT_UP)),
        .i_rotate_dn (w_rotate && w_is_act && (shift_dir == ROT_DN)),
        .o_head      (w_head[b]),
        .o_tail      (w_tail[b])
      );
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign act_valid = r_act_valid;
  assign out_head  = r_act_valid ? w_head[r_act_sel] : '0;
  assign out_tail  = r_act_valid ? w_tail[r_act_sel] : '0;
  assign rot_cnt   = r_rot_cnt;
  assign rot_wrap  = r_rot_wrap;

endmodule : cir_reg_w_pp
`default_nettype wire

// File: tb/tb_cir_reg_w_pp.sv
`default_nettype none
// ============================================================================
// Module      : tb_cir_reg_w_pp
// Description : Self-checking bench for cir_reg_w_pp. A reference model keeps
//               the shadow as a queue of loaded columns and the active bank as
//               the loaded column list plus a rotation offset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cir_reg_w_pp;

  localparam int DW  = 8;
  localparam int K_H = 3;
  localparam int K_W = 3;
  localparam int CW  = $clog2(K_W);
  localparam int VW  = 3 + CW + 2 * K_H * DW;

  typedef logic [K_H-1:0][DW-1:0] col_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  col_t            in_data = '0;
  logic            shift_en = 1'b0;
  logic            shift_dir = 1'b0;
  logic            bank_release = 1'b0;
  logic            act_valid;
  col_t            out_head;
  col_t            out_tail;
  logic [CW-1:0]   rot_cnt;
  logic            rot_wrap;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cir_reg_w_pp #(.DW(DW), .K_H(K_H), .K_W(K_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .shift_en     (shift_en),
    .shift_dir    (shift_dir),
    .bank_release (bank_release),
    .act_valid    (act_valid),
    .out_head     (out_head),
    .out_tail     (out_tail),
    .rot_cnt      (rot_cnt),
    .rot_wrap     (rot_wrap)
  );

  // ---------------- reference model ----------------
  col_t m_shadow[$];      // columns in load order
  col_t m_act[K_W];       // active set, in load order
  bit   m_av;
  int   m_rot;
  bit   m_wrap;

  function automatic void model_reset();
    m_shadow.delete();
    for (int k = 0; k < K_W; k++) m_act[k] = '0;
    m_av = 0; m_rot = 0; m_wrap = 0;
  endfunction

  // The k-th loaded column ends at index K_W-1-k; rotating up by r moves the
  // content at index j to index j+r.
  function automatic col_t m_col(int j);
    int idx;
    if (!m_av) return '0;
    idx = (((j - m_rot) % K_W) + K_W) % K_W;
    return m_act[K_W-1-idx];
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic rdy;
    rdy = (m_shadow.size() < K_W) && !clear;
    return {rdy, m_av, CW'(m_rot), m_wrap, m_col(0), m_col(K_W-1)};
  endfunction

  function automatic void model_step(bit v, col_t d, bit sh, bit dir, bit rel, bit clr);
    bit full, swp, rel_e, rot;
    if (clr) begin model_reset(); return; end
    full  = (m_shadow.size() == K_W);
    swp   = full && (!m_av || rel);
    rel_e = rel && !full;
    rot   = m_av && sh && !swp && !rel_e;
    m_wrap = 0;
    if (swp) begin
      for (int k = 0; k < K_W; k++) m_act[k] = m_shadow[k];
      m_shadow.delete();
      m_av = 1; m_rot = 0;
    end else if (rel_e) begin
      m_av = 0;
    end else if (rot) begin
      m_rot  = dir ? (m_rot + K_W - 1) % K_W : (m_rot + 1) % K_W;
      m_wrap = (m_rot == 0);
    end
    if (v && !full) m_shadow.push_back(d);
  endfunction

  function automatic col_t mk(int a, int b, int c);
    col_t t;
    t[0] = DW'(a); t[1] = DW'(b); t[2] = DW'(c);
    return t;
  endfunction

  function automatic col_t rnd_col();
    col_t t;
    for (int i = 0; i < K_H; i++) t[i] = DW'($urandom);
    return t;
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, settle.
  task automatic drive(bit v, col_t d, bit sh, bit dir, bit rel, bit clr);
    in_valid = v; in_data = d; shift_en = sh; shift_dir = dir;
    bank_release = rel; clear = clr;
    @(posedge clk);
    model_step(v, d, sh, dir, rel, clr);
    #1;
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    #1;
    checks++;
    if ({in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail} !== {1'b1, 1'b0, CW'(0), 1'b0, col_t'(0), col_t'(0)}) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", {in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail}, exp_vec());
    end
    for (int n = 0; n < 3; n++) begin
      drive(0, '0, 1, n[0], 0, 0);
      checks++;
      if ({in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail} !== exp_vec()) begin
        failures++;
        $display("FAIL idle_shift got=%h want=%h", {in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail}, exp_vec());
      end
    end
  endtask

  task automatic test_load_swap();
    drive(1, mk(1,2,3), 0, 0, 0, 0);
    drive(1, mk(4,5,6), 0, 0, 0, 0);
    drive(1, mk(7,8,9), 0, 0, 0, 0);
    checks++;
    if ({in_ready, act_valid} !== 2'b00) begin
      failures++;
      $display("FAIL full_before_swap ready/valid got=%b want=00", {in_ready, act_valid});
    end
    idle();
    checks++;
    if ({act_valid, out_head, out_tail, rot_cnt, in_ready} !== {1'b1, mk(7,8,9), mk(1,2,3), CW'(0), 1'b1}) begin
      failures++;
      $display("FAIL swap_outputs got=%h want=%h", {act_valid, out_head, out_tail, rot_cnt, in_ready},
               {1'b1, mk(7,8,9), mk(1,2,3), CW'(0), 1'b1});
    end
  endtask

  task automatic test_rotate();
    col_t heads_up[3];
    int   rots[3];
    int   wraps;
    heads_up[0] = mk(1,2,3); heads_up[1] = mk(4,5,6); heads_up[2] = mk(7,8,9);
    wraps = 0;
    for (int n = 0; n < 3; n++) begin
      drive(0, '0, 1, 0, 0, 0);
      rots[n] = rot_cnt;
      wraps += rot_wrap;
      checks++;
      if (out_head !== heads_up[n] || rot_cnt !== CW'((n + 1) % 3)) begin
        failures++;
        $display("FAIL rot_up step%0d head=%h rot=%0d want head=%h rot=%0d", n, out_head, rot_cnt, heads_up[n], (n + 1) % 3);
      end
    end
    idle();
    wraps += rot_wrap;
    checks++;
    if (wraps !== 1) begin
      failures++;
      $display("FAIL rot_up_wrap_count got=%0d want=1", wraps);
    end
    wraps = 0;
    for (int n = 0; n < 3; n++) begin
      drive(0, '0, 1, 1, 0, 0);
      wraps += rot_wrap;
      checks++;
      if ({in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail} !== exp_vec() || rot_cnt !== CW'(2 - n)) begin
        failures++;
        $display("FAIL rot_dn step%0d got=%h want=%h", n, {in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail}, exp_vec());
      end
    end
    idle();
    wraps += rot_wrap;
    checks++;
    if (wraps !== 1) begin
      failures++;
      $display("FAIL rot_dn_wrap_count got=%0d want=1", wraps);
    end
  endtask

  task automatic test_ping_pong();
    for (int n = 0; n < 3; n++) drive(1, mk(10+3*n, 11+3*n, 12+3*n), 1, 0, 0, 0);
    drive(0, '0, 1, 0, 0, 0);
    checks++;
    if ({in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail} !== exp_vec() || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL pp_full got=%h want=%h", {in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail}, exp_vec());
    end
    drive(0, '0, 1, 0, 1, 0);
    checks++;
    if ({act_valid, in_ready, rot_cnt, rot_wrap, out_head, out_tail} !== {2'b11, CW'(0), 1'b0, mk(16,17,18), mk(10,11,12)}) begin
      failures++;
      $display("FAIL pp_swap got=%h want=%h", {act_valid, in_ready, rot_cnt, rot_wrap, out_head, out_tail},
               {2'b11, CW'(0), 1'b0, mk(16,17,18), mk(10,11,12)});
    end
  endtask

  task automatic test_release_empty();
    logic [CW-1:0] rot_before;
    drive(0, '0, 1, 0, 0, 0);
    rot_before = rot_cnt;
    drive(0, '0, 1, 0, 1, 0);
    checks++;
    if ({act_valid, out_head, out_tail, rot_cnt, rot_wrap} !== {1'b0, col_t'(0), col_t'(0), rot_before, 1'b0}
        || {in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail} !== exp_vec()) begin
      failures++;
      $display("FAIL release_empty got=%h want=%h", {in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail}, exp_vec());
    end
  endtask

  task automatic test_clear();
    for (int n = 0; n < 3; n++) drive(1, rnd_col(), 0, 0, 0, 0);
    idle();
    drive(1, rnd_col(), 1, 0, 0, 0);
    drive(1, rnd_col(), 1, 0, 0, 0);
    drive(1, rnd_col(), 1, 0, 0, 1);
    idle();
    checks++;
    if ({in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail} !== {2'b10, CW'(0), 1'b0, col_t'(0), col_t'(0)}) begin
      failures++;
      $display("FAIL clear_state got=%h want=%h", {in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail}, exp_vec());
    end
    drive(1, mk(1,2,3), 0, 0, 0, 0);
    drive(1, mk(4,5,6), 0, 0, 0, 0);
    drive(1, mk(7,8,9), 0, 0, 0, 0);
    idle();
    checks++;
    if ({act_valid, out_head, out_tail} !== {1'b1, mk(7,8,9), mk(1,2,3)}) begin
      failures++;
      $display("FAIL clear_reload got=%h want=%h", {act_valid, out_head, out_tail}, {1'b1, mk(7,8,9), mk(1,2,3)});
    end
  endtask

  task automatic test_async_reset();
    drive(1, rnd_col(), 1, 0, 0, 0);
    drive(1, rnd_col(), 1, 1, 0, 0);
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail} !== {2'b10, CW'(0), 1'b0, col_t'(0), col_t'(0)}) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", {in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail}, exp_vec());
    end
    @(negedge clk);
    rst_n = 1;
    drive(1, mk(1,2,3), 0, 0, 0, 0);
    drive(1, mk(4,5,6), 0, 0, 0, 0);
    drive(1, mk(7,8,9), 0, 0, 0, 0);
    idle();
    checks++;
    if ({act_valid, out_head, out_tail, rot_cnt} !== {1'b1, mk(7,8,9), mk(1,2,3), CW'(0)}) begin
      failures++;
      $display("FAIL reset_reload got=%h want=%h", {act_valid, out_head, out_tail, rot_cnt}, {1'b1, mk(7,8,9), mk(1,2,3), CW'(0)});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), rnd_col(), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0);
      checks++;
      if ({in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail} !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc%0d got=%h want=%h", n, {in_ready, act_valid, rot_cnt, rot_wrap, out_head, out_tail}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_swap();
    test_rotate();
    test_ping_pong();
    test_release_empty();
    test_clear();
    test_async_reset();
    test_random();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cir_reg_w_pp
`default_nettype wire

// File: doc/cir_reg_w_pp.md
# cir_reg_w_pp

Double-buffered, parametrised circular weight register for the PE array weight path. One bank is loaded column by column through a valid/ready handshake while the other, active bank rotates circularly to feed the PE, in either direction. Banks swap automatically when the loaded bank is full and the active bank is free or released. It provides head and tail column taps, a rotation counter and a wrap pulse for the controller.

## Interface
- DW, 8, data width per element
- K_H, 3, rows (kernel height, one output lane per row)
- K_W, 3, columns (kernel width, ring length); K_W ≥ 2
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear of all state
- in_valid  in  1  load column valid
- in_ready  out  1  shadow bank can accept a column
- in_data  in  [K_H] x DW  load column, element i goes to row i
- shift_en  in  1  rotate active bank one position
- shift_dir  in  1  0 = rotate toward higher column index, 1 = toward lower
- release  in  1  consumer finished with active bank
- act_valid  out  1  active bank holds valid weights
- out_head  out  [K_H] x DW  active bank column 0
- out_tail  out  [K_H] x DW  active bank column K_W-1
- rot_cnt  out  $clog2(K_W)  rotation position of active bank, 0..K_W-1
- rot_wrap  out  1  one-cycle pulse, rotation returned to position 0

## Operation
- Two banks, each K_H x K_W x DW, covering all rows 0..K_H-1. act_sel selects the active bank and the other is the shadow. col_cnt (0..K_W) tracks shadow fill.
- in_ready = (col_cnt < K_W) && !clear.
- Load, when in_valid && in_ready: shadow[i][j] <= shadow[i][j-1] for j ≥ 1, shadow[i][0] <= in_data[i], col_cnt++. The first accepted column ends at column K_W-1.
- Swap when col_cnt == K_W && (!act_valid || release):
  - act_sel toggles, act_valid <= 1, rot_cnt <= 0, col_cnt <= 0.
  - The old active contents are don't-care and are overwritten by later loads.
- Release when col_cnt < K_W: act_valid <= 0.
- Rotate, only when act_valid && shift_en && no swap/release this cycle:
  - dir 0: a[i][j] <= a[i][j-1], a[i][0] <= a[i][K_W-1]; rot_cnt increments mod K_W.
  - dir 1: a[i][j] <= a[i][j+1], a[i][K_W-1] <= a[i][0]; rot_cnt decrements mod K_W.
- shift_en with act_valid=0 is ignored.
- Priority: rst_n > clear > swap/release > shift. Load is independent of the active bank. When a swap is possible, in_ready is 0, so a load and a swap never coincide.
- out_head and out_tail are combinational from the active bank, and forced to 0 when act_valid=0.

## Timing
- Reset (async) and clear (sync) give: all storage 0, col_cnt 0, act_sel 0, act_valid 0, rot_cnt 0, rot_wrap 0, in_ready 1 (with clear low).
- Load latency: a column accepted at edge N is visible in the shadow after edge N.
- Swap: the K_W-th load at edge N gives col_cnt=K_W; swap at edge N+1 at the earliest; act_valid and new outputs are valid after that edge. in_ready is low from N+1 until the swap edge.
- Release with shadow full: swap on the same edge, with no gap in act_valid.
- rot_wrap is registered. It is high for exactly the cycle after a rotate edge that sets rot_cnt to 0, in either direction, and never on swap.
- clear during a load or rotation aborts it: a partial shadow is discarded and act_valid drops after that edge.

## Structure
- Package cir_reg_pkg: default DW/K_H/K_W localparams, the dir encoding constants (ROT_UP=0, ROT_DN=1) and a weight element typedef.
- Sub-module cir_bank: one K_H x K_W bank with load, rotate_up, rotate_dn and clr controls and head/tail taps. It is instantiated twice. The top holds act_sel, col_cnt, act_valid, rot_cnt, rot_wrap and the muxes.

## Test plan
- Reset/idle -> act_valid=0, in_ready=1, out_head=out_tail=0, rot_cnt=0; shift_en pulses change nothing.
- Load columns {1,2,3},{4,5,6},{7,8,9} -> after the swap edge, act_valid=1, out_head={7,8,9}, out_tail={1,2,3}.
- Three dir-0 shifts -> out_head sequence {1,2,3},{4,5,6},{7,8,9}; rot_cnt 1,2,0; single rot_wrap pulse after the third shift. Repeat with dir 1 -> rot_cnt 2,1,0, one wrap.
- Ping-pong: while bank A rotates, load {10..18} -> in_ready=0 after 3 columns. Pulse release -> the same edge swaps in the new set, act_valid stays 1, in_ready returns to 1, rot_cnt=0.
- release with an empty shadow, asserted together with shift_en -> act_valid=0, outputs 0, rot_cnt unchanged, no rotate.
- clear after 2 loaded columns while active -> all outputs 0 and col_cnt 0. A fresh 3-column load then behaves as in scenario 2. An asynchronous rst_n mid-rotation gives the same result.
